// File: rtl/activation.sv
// activation: per-lane activation stage behind the pooling block.
// Applies ReLU, leaky ReLU or ReLU6 to Q8.8 lanes, or passes them through
// unchanged. Latency is always two cycles. A small FSM tracks burst
// activity and raises a sticky done flag once the pipeline has drained.
//
// Handshake: in_data_available qualifies inp_data and its control fields
// (enable_activation, activation_type, validity_mask) in the same cycle;
// there is no backpressure. out_data_available qualifies out_data exactly
// two cycles later, and out_data holds its value when not qualified.
module activation #(
  parameter int DWIDTH      = 16,
  parameter int DESIGN_SIZE = 16,
  parameter int MASK_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int LEAK_SHIFT  = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_activation,
  input  logic [1:0]                    activation_type,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]         validity_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic [CNT_WIDTH-1:0]          vector_count,
  output logic                          done_activation,
  output logic [1:0]                    fsm_state
);

  localparam int VW = DESIGN_SIZE * DWIDTH;

  // Saturation ceiling for ReLU6 (6.0 in the lane's Q format).
  localparam logic signed [DWIDTH-1:0] ONE6 = DWIDTH'(6 << FRAC_BITS);

  // Burst FSM encoding.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Idle cycles needed after the last input before both stages are empty.
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  logic [VW-1:0]          act_lanes;
  logic                   bypass;
  logic signed [DWIDTH-1:0] lane_x;
  logic signed [DWIDTH-1:0] lane_y;

  logic [VW-1:0]          s1_data_q, s1_data_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [VW-1:0]          out_data_q, out_data_d;
  logic                   out_avail_q, out_avail_d;
  logic [1:0]             state_q, state_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   start_burst;

  // Per-lane activation function, applied to the incoming vector.
  always_comb begin
    act_lanes = '0;
    lane_x    = '0;
    lane_y    = '0;
    bypass    = !enable_activation || (activation_type == 2'd3);
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      lane_x = $signed(inp_data[i*DWIDTH +: DWIDTH]);
      lane_y = lane_x;
      if (!bypass) begin
        case (activation_type)
          2'd0: if (lane_x[DWIDTH-1]) lane_y = '0;
          2'd1: if (lane_x[DWIDTH-1]) lane_y = lane_x >>> LEAK_SHIFT;
          2'd2: begin
            if (lane_x[DWIDTH-1])   lane_y = '0;
            else if (lane_x > ONE6) lane_y = ONE6;
          end
          default: lane_y = lane_x;
        endcase
      end
      // Masked lanes are zeroed in every mode, bypass included.
      if (!validity_mask[i]) lane_y = '0;
      act_lanes[i*DWIDTH +: DWIDTH] = lane_y;
    end
  end

  // Two-stage datapath: stage 1 captures activated lanes, stage 2 drives out.
  always_comb begin
    s1_valid_d  = in_data_available;
    s1_data_d   = in_data_available ? act_lanes : s1_data_q;
    out_avail_d = s1_valid_q;
    out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
  end

  // Burst tracking: the idle cycle seen while ACTIVE is the first drain cycle.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    start_burst = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_data_available) begin
          state_d     = S_ACTIVE;
          start_burst = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!in_data_available) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd1;
        end
      end
      S_DRAIN: begin
        if (in_data_available) begin
          state_d     = S_ACTIVE;
          drain_cnt_d = 2'd0;
        end else if (drain_cnt_q == DRAIN_CYCLES - 2'd1) begin
          state_d     = S_DONE;
          drain_cnt_d = 2'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        if (in_data_available) begin
          state_d     = S_ACTIVE;
          start_burst = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Vector counter: restarts on a new burst, counting a coincident pulse.
  always_comb begin
    count_d = count_q;
    if (start_burst)      count_d = out_avail_q ? CNT_WIDTH'(1) : '0;
    else if (out_avail_q) count_d = count_q + CNT_WIDTH'(1);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_avail_q <= 1'b0;
      state_q     <= S_IDLE;
      drain_cnt_q <= 2'd0;
      count_q     <= '0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_avail_q <= out_avail_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      count_q     <= count_d;
    end
  end

  assign out_data           = out_data_q;
  assign out_data_available = out_avail_q;
  assign vector_count       = count_q;
  assign done_activation    = (state_q == S_DONE);
  assign fsm_state          = state_q;

endmodule

// File: tb/tb_activation.sv
// tb_activation: randomized and directed stimulus for the activation stage,
// checked every cycle against a behavioural model of the stage's rules.
module tb_activation;

  localparam int DW   = 16;
  localparam int DS   = 16;
  localparam int VW   = DW * DS;
  localparam int MAXC = 4096;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable_activation = 1'b1;
  logic [1:0]    activation_type = 2'd0;
  logic          in_data_available = 1'b0;
  logic [VW-1:0] inp_data = '0;
  logic [15:0]   validity_mask = 16'hFFFF;
  logic [VW-1:0] out_data;
  logic          out_data_available;
  logic [15:0]   vector_count;
  logic          done_activation;
  logic [1:0]    fsm_state;

  activation dut (
    .clk(clk), .reset(reset),
    .enable_activation(enable_activation), .activation_type(activation_type),
    .in_data_available(in_data_available), .inp_data(inp_data),
    .validity_mask(validity_mask), .out_data(out_data),
    .out_data_available(out_data_available), .vector_count(vector_count),
    .done_activation(done_activation), .fsm_state(fsm_state)
  );

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rst_base = 1;
  int last_in = -1;
  int start_c = -1;
  logic          in_v [MAXC];
  logic [VW-1:0] exp_vec [MAXC];
  logic [VW-1:0] exp_out = '0;
  logic [VW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit inv(input int c);
    if (c < rst_base) return 1'b0;
    return in_v[c % MAXC];
  endfunction

  // Reference lane function from the arithmetic definition of each mode.
  function automatic logic [15:0] lane_ref(input logic [15:0] x, input bit valid,
                                           input bit en, input logic [1:0] t);
    int v;
    int r;
    v = int'($signed(x));
    if (!valid) return 16'h0000;
    if (!en || t == 2'd3) return x;
    case (t)
      2'd0: r = (v < 0) ? 0 : v;
      2'd1: r = (v < 0) ? -((-v + 7) / 8) : v;
      default: r = (v < 0) ? 0 : ((v > 1536) ? 1536 : v);
    endcase
    return r[15:0];
  endfunction

  function automatic logic [VW-1:0] vec_ref(input logic [VW-1:0] d, input logic [15:0] m,
                                            input bit en, input logic [1:0] t);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < DS; i++) r[i*DW +: DW] = lane_ref(d[i*DW +: DW], m[i], en, t);
    return r;
  endfunction

  // Compare all outputs of the current cycle against the model.
  task automatic check_outputs();
    bit exp_avail;
    bit exp_done;
    logic [15:0] exp_cnt;
    exp_avail = inv(cyc - 2);
    if (exp_avail) begin
      exp_out = exp_q.pop_front();
      check_eq("vec_order", exp_out, exp_vec[(cyc - 2) % MAXC]);
    end
    exp_done = !inv(cyc - 1) && !inv(cyc - 2) && (last_in >= rst_base);
    exp_cnt = '0;
    if (start_c >= rst_base)
      for (int d = start_c; d < cyc; d++) if (inv(d - 2)) exp_cnt++;
    check_eq("out_avail", VW'(out_data_available), VW'(exp_avail));
    check_eq("out_data", out_data, exp_out);
    check_eq("done", VW'(done_activation), VW'(exp_done));
    check_eq("vector_count", VW'(vector_count), VW'(exp_cnt));
  endtask

  // Driver: one cycle of stimulus, checked before the new inputs are applied.
  task automatic step(input bit v, input logic [VW-1:0] d, input logic [15:0] m,
                      input bit en, input logic [1:0] t);
    @(negedge clk);
    cyc++;
    check_outputs();
    in_data_available = v;
    inp_data          = d;
    validity_mask     = m;
    enable_activation = en;
    activation_type   = t;
    in_v[cyc % MAXC]  = v;
    if (v) begin
      if (!inv(cyc - 1) && !inv(cyc - 2)) start_c = cyc;
      last_in = cyc;
      exp_vec[cyc % MAXC] = vec_ref(d, m, en, t);
      exp_q.push_back(vec_ref(d, m, en, t));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 16'hFFFF, 1'b1, 2'd0);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    logic [15:0] pick [8];
    pick = '{16'h0000, 16'h0600, 16'h0601, 16'h05FF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFF00};
    for (int i = 0; i < DS; i++)
      r[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 16'($urandom);
    return r;
  endfunction

  // Asynchronous reset in mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    in_data_available = 1'b0;
    #1;
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_avail", VW'(out_data_available), '0);
    check_eq("rst_count", VW'(vector_count), '0);
    check_eq("rst_done", VW'(done_activation), '0);
    check_eq("rst_fsm", VW'(fsm_state), '0);
    @(negedge clk);
    cyc++;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    rst_base = cyc + 1;
    exp_out = '0;
    last_in = -1;
    start_c = -1;
    exp_q.delete();
  endtask

  logic [VW-1:0] v;

  initial begin
    // Initial reset state
    repeat (2) @(negedge clk);
    check_eq("init_out_data", out_data, '0);
    check_eq("init_avail", VW'(out_data_available), '0);
    check_eq("init_count", VW'(vector_count), '0);
    check_eq("init_done", VW'(done_activation), '0);
    check_eq("init_fsm", VW'(fsm_state), '0);
    reset = 1'b0;
    cyc = 0;
    rst_base = 1;
    idle(2);

    // 1: ReLU ramp -8.0 .. 7.0
    for (int i = 0; i < DS; i++) v[i*DW +: DW] = 16'((i - 8) << 8);
    step(1'b1, v, 16'hFFFF, 1'b1, 2'd0);
    idle(2);
    check_eq("t1_lane0", VW'(out_data[0 +: DW]), VW'(16'h0000));
    check_eq("t1_lane9", VW'(out_data[9*DW +: DW]), VW'(16'h0100));
    check_eq("t1_lane15", VW'(out_data[15*DW +: DW]), VW'(16'h0700));
    idle(1);
    check_eq("t1_done", VW'(done_activation), VW'(1'b1));
    check_eq("t1_count", VW'(vector_count), VW'(16'd1));
    idle(2);

    // 2: leaky ReLU corner values
    v = rand_vec();
    v[0 +: 64] = {16'h0180, 16'hFFFF, 16'hFF80, 16'hFF00};
    step(1'b1, v, 16'hFFFF, 1'b1, 2'd1);
    idle(2);
    check_eq("t2_lanes", VW'(out_data[0 +: 64]), VW'(64'h0180_FFFF_FFF0_FFE0));
    idle(2);

    // 3: ReLU6 limits, lane 0 masked in every mode
    v = rand_vec();
    v[0 +: 64] = {16'h8000, 16'h05FF, 16'h0600, 16'h0700};
    step(1'b1, v, 16'hFFFE, 1'b1, 2'd2);
    step(1'b1, v, 16'hFFFE, 1'b1, 2'd0);
    step(1'b1, v, 16'hFFFE, 1'b1, 2'd1);
    step(1'b1, v, 16'hFFFE, 1'b1, 2'd3);
    step(1'b1, v, 16'hFFFE, 1'b0, 2'd2);
    idle(4);

    // 4: bypass with a one-cycle gap, then a fresh burst
    step(1'b1, rand_vec(), 16'hFFFF, 1'b0, 2'd1);
    step(1'b1, rand_vec(), 16'hFFFF, 1'b0, 2'd1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 16'hFFFF, 1'b0, 2'd1);
    idle(4);
    check_eq("t4_count", VW'(vector_count), VW'(16'd5));
    step(1'b1, rand_vec(), 16'hFFFF, 1'b0, 2'd1);
    idle(4);

    // 5: reset with two vectors in flight
    step(1'b1, rand_vec(), 16'hFFFF, 1'b1, 2'd0);
    step(1'b1, rand_vec(), 16'hFFFF, 1'b1, 2'd1);
    step(1'b0, '0, 16'hFFFF, 1'b1, 2'd0);
    async_reset();
    idle(4);

    // 6: restart during drain
    for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 16'hFFFF, 1'b1, 2'd2);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 16'hFFFF, 1'b1, 2'd2);
    idle(4);
    check_eq("t6_count", VW'(vector_count), VW'(16'd6));

    // Random bursts with random gaps and per-vector controls
    for (int b = 0; b < 25; b++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        step(1'b1, rand_vec(),
             ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF,
             1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)));
      idle($urandom_range(0, 4));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/activation.md
Name: activation

Overview:
- Stage directly downstream of the pooling block in the TPU output datapath.
- Consumes pooled Q8.8 vectors (DESIGN_SIZE lanes) and applies a per-lane activation function: ReLU, leaky ReLU or ReLU6.
- Fixed 2-cycle latency; supports a bypass mode.
- Signals done_activation once a burst has fully drained, so the output writer can close the tile.

Parameters:
DWIDTH, 16, lane width; signed Q8.8 fixed point
DESIGN_SIZE, 16, lanes per vector
MASK_WIDTH, 16, validity mask width; equals DESIGN_SIZE
FRAC_BITS, 8, fractional bits of the Q format
LEAK_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAK_SHIFT
CNT_WIDTH, 16, width of vector_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable_activation  input  1  0 = bypass (data passes unchanged, same latency)
activation_type  input  2  0 = ReLU, 1 = leaky ReLU, 2 = ReLU6, 3 = treated as bypass
in_data_available  input  1  inp_data valid this cycle
inp_data  input  DESIGN_SIZE*DWIDTH  packed lanes; lane i = bits [i*DWIDTH +: DWIDTH]
validity_mask  input  MASK_WIDTH  bit i = 0 forces output lane i to 0
out_data  output  DESIGN_SIZE*DWIDTH  activated lanes
out_data_available  output  1  out_data valid this cycle
vector_count  output  CNT_WIDTH  vectors emitted in the current burst
done_activation  output  1  burst fully drained; sticky

Behaviour:
- Reset (asynchronous, any time, including mid-burst) clears all state and outputs:
  - out_data = 0, out_data_available = 0, vector_count = 0, done_activation = 0.
  - Pipeline valid bits = 0; FSM = IDLE.
  - In-flight vectors are discarded.
- Pipeline:
  - Stage 1 registers the computed lanes plus a valid bit on each edge where in_data_available = 1.
  - Stage 2 registers out_data and out_data_available.
  - An input valid in cycle k appears with out_data_available = 1 in cycle k+2.
  - Gaps in in_data_available appear as identical gaps at the output.
  - out_data holds its last value while out_data_available = 0.
- Control capture:
  - enable_activation, activation_type and validity_mask are sampled together with the data.
  - Changing them mid-burst affects only subsequent vectors.
- Per-lane function (x signed DWIDTH, ONE6 = 6 << FRAC_BITS = 0x0600):
  - Bypass (enable = 0, or type = 3): y = x.
  - ReLU: y = (x < 0) ? 0 : x.
  - Leaky: y = (x < 0) ? x >>> LEAK_SHIFT : x. Arithmetic shift, rounds toward minus infinity; no saturation needed.
  - ReLU6: y = (x < 0) ? 0 : (x > ONE6) ? ONE6 : x.
  - Mask: if validity_mask[i] = 0, y = 0 regardless of mode, including bypass.
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE → ACTIVE when in_data_available = 1.
  - ACTIVE → DRAIN when in_data_available = 0.
  - DRAIN counts 2 cycles, then → DONE. If in_data_available = 1 during DRAIN, → ACTIVE (the vector is accepted and the drain counter clears).
  - DONE: done_activation = 1, held until in_data_available = 1. That same edge clears done, moves to ACTIVE and accepts the vector.
  - done_activation asserts in the cycle after the last out_data_available pulse.
- vector_count:
  - Increments on each cycle with out_data_available = 1.
  - Clears to 0 on the IDLE→ACTIVE or DONE→ACTIVE transition edge.
  - When that transition coincides with an output pulse, the result is 1, not the old count + 1.
  - Wraps modulo 2^CNT_WIDTH.

Test Plan:
1. ReLU, all lanes valid, lane i = q8.8(i-8, 0): 0xF800..0x0700 → out lanes 0..8 = 0x0000, lane 9 = 0x0100 … lane 15 = 0x0700. out_data_available exactly 2 cycles after input; done_activation the cycle after the last output; vector_count = 1.
2. Leaky (type 1), inputs 0xFF00 (-1.0), 0xFF80 (-0.5), 0xFFFF, 0x0180 → 0xFFE0, 0xFFF0, 0xFFFF, 0x0180.
3. ReLU6, inputs 0x0700, 0x0600, 0x05FF, 0x8000 → 0x0600, 0x0600, 0x05FF, 0x0000. validity_mask = 0xFFFE → lane 0 = 0 in every mode, including bypass.
4. Bypass (enable_activation = 0, type = 1), 5 back-to-back vectors with a one-cycle gap after the 2nd → outputs equal inputs with the same gap pattern; vector_count = 5; done_activation only after the 5th output. A new burst clears done on its first accepted cycle and restarts the count at 1.
5. Assert reset while 2 vectors are in the pipeline → all outputs 0 immediately (asynchronously, before the next clock edge); no out_data_available pulse afterwards; FSM = IDLE.
6. Restart during DRAIN: in_data_available drops for 1 cycle then rises → no done_activation pulse; done asserts only after the final burst drains; vector_count covers both segments.
